// File: rtl/sq_sum_if.sv
// Handshake and result bundle for sq_sum. Defining SQSUM_CHECK_EN adds the
// root operand and the ok flag.
interface sq_sum_if;
  logic        start;
  logic [4:0]  in1;
  logic [4:0]  in2;
  logic [10:0] O;
  logic        done;
  logic        busy;
  logic [3:0]  state;
`ifdef SQSUM_CHECK_EN
  logic [4:0]  root;
  logic        ok;

  modport master (output start, in1, in2, root, input O, done, busy, state, ok);
  modport slave  (input start, in1, in2, root, output O, done, busy, state, ok);
`else
  modport master (output start, in1, in2, input O, done, busy, state);
  modport slave  (input start, in1, in2, output O, done, busy, state);
`endif
endinterface

// File: rtl/sq_sum.sv
// Sequential x*x + y*y using one shared 5-step shift-add squarer.
// Optional SQSUM_CHECK_EN adds a root bracket check (r*r <= O <= (r+1)^2).
module sq_sum (
  input  logic     clk,
  input  logic     rst_n,
  sq_sum_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LOAD = 4'd1,
    SQ1  = 4'd2,
    SQ2  = 4'd3,
    ADD  = 4'd4,
`ifdef SQSUM_CHECK_EN
    SQ3  = 4'd5,
    CHK  = 4'd6,
`endif
    DONE = 4'd7
  } state_t;

  state_t      state_reg;
  logic [4:0]  x_reg;
  logic [4:0]  y_reg;
  logic [2:0]  cnt_reg;
  logic [9:0]  acc_reg;
  logic [9:0]  p1_reg;
  logic [10:0] o_reg;
  logic        done_reg;
  logic        busy_reg;
`ifdef SQSUM_CHECK_EN
  logic [4:0]  r_reg;
  logic        ok_reg;
  logic [10:0] sq_ext;
  logic [10:0] upper;
`endif

  logic [4:0]  mul_op;
  logic        mul_bit;
  logic [9:0]  partial;
  logic [9:0]  step;
  logic        last;

  // Operand feeding the shared squarer depends on which squaring phase is active.
  always_comb begin
    mul_op = x_reg;
    case (state_reg)
      SQ2:     mul_op = y_reg;
`ifdef SQSUM_CHECK_EN
      SQ3:     mul_op = r_reg;
`endif
      default: mul_op = x_reg;
    endcase
  end

  assign mul_bit = |(mul_op & (5'b00001 << cnt_reg));
  assign partial = ({5'b00000, mul_op} << cnt_reg) & {10{mul_bit}};
  assign step    = acc_reg + partial;
  assign last    = (cnt_reg == 3'd4);

`ifdef SQSUM_CHECK_EN
  assign sq_ext = {1'b0, acc_reg};
  assign upper  = sq_ext + {5'b00000, r_reg, 1'b0} + 11'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      p1_reg    <= '0;
      o_reg     <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef SQSUM_CHECK_EN
      r_reg     <= '0;
      ok_reg    <= 1'b0;
`endif
    end else begin
      // done and busy are registered from the state being entered
      done_reg <= 1'b0;
      busy_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (bus.start) state_reg <= LOAD;
          else           busy_reg  <= 1'b0;
        end
        LOAD: begin
          x_reg     <= bus.in1;
          y_reg     <= bus.in2;
`ifdef SQSUM_CHECK_EN
          r_reg     <= bus.root;
`endif
          acc_reg   <= '0;
          cnt_reg   <= '0;
          state_reg <= SQ1;
        end
        SQ1: begin
          cnt_reg <= last ? 3'd0 : cnt_reg + 3'd1;
          acc_reg <= last ? 10'd0 : step;
          if (last) begin
            p1_reg    <= step;
            state_reg <= SQ2;
          end
        end
        SQ2: begin
          acc_reg <= step;
          cnt_reg <= last ? 3'd0 : cnt_reg + 3'd1;
          if (last) state_reg <= ADD;
        end
        ADD: begin
          o_reg <= {1'b0, p1_reg} + {1'b0, acc_reg};
`ifdef SQSUM_CHECK_EN
          acc_reg   <= '0;
          cnt_reg   <= '0;
          state_reg <= SQ3;
`else
          done_reg  <= 1'b1;
          state_reg <= DONE;
`endif
        end
`ifdef SQSUM_CHECK_EN
        SQ3: begin
          acc_reg <= step;
          cnt_reg <= last ? 3'd0 : cnt_reg + 3'd1;
          if (last) state_reg <= CHK;
        end
        CHK: begin
          ok_reg    <= (sq_ext <= o_reg) && (o_reg <= upper);
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
`endif
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.O     = o_reg;
  assign bus.done  = done_reg;
  assign bus.busy  = busy_reg;
  assign bus.state = state_reg;
`ifdef SQSUM_CHECK_EN
  assign bus.ok    = ok_reg;
`endif

endmodule

// File: tb/tb_sq_sum.sv
// Randomised self-checking bench for sq_sum against an arithmetic reference model.
// Builds with or without SQSUM_CHECK_EN.
module tb_sq_sum;

`ifdef SQSUM_CHECK_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 13;
`endif
  localparam int P = LAT + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sq_sum_if bus ();

  sq_sum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int model_o(input int x, input int y);
    return x * x + y * y;
  endfunction

  function automatic logic model_ok(input int o, input int r);
    return (r * r <= o) && (o <= (r + 1) * (r + 1));
  endfunction

  // Issues a single-cycle start and watches LAT+2 cycles; cycle 1 is the first after the accepting edge.
  task automatic run_op(input logic [4:0] x, input logic [4:0] y, input logic [4:0] r,
                        output logic [10:0] o, output logic okv,
                        output int dc, output int dcnt, output int bcnt);
    bus.in1 = x;
    bus.in2 = y;
`ifdef SQSUM_CHECK_EN
    bus.root = r;
`else
    if (r > 5'd31) $display("unreachable");
`endif
    bus.start = 1'b1;
    dc = -1; dcnt = 0; bcnt = 0; o = '0; okv = 1'b0;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.start = 1'b0;
      if (c == 3) begin
        bus.in1 = 5'($urandom_range(31));
        bus.in2 = 5'($urandom_range(31));
`ifdef SQSUM_CHECK_EN
        bus.root = 5'($urandom_range(31));
`endif
      end
      if (bus.busy) bcnt++;
      if (bus.done) begin
        dcnt++;
        if (dc < 0) begin
          dc = c;
          o  = bus.O;
`ifdef SQSUM_CHECK_EN
          okv = bus.ok;
`endif
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.O !== 11'd0) begin failures++; $display("FAIL reset_O got=%0d exp=0", bus.O); end
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL reset_flags done=%b busy=%b exp=0/0", bus.done, bus.busy); end
`ifdef SQSUM_CHECK_EN
    checks++; if (bus.ok !== 1'b0) begin failures++; $display("FAIL reset_ok got=%b exp=0", bus.ok); end
`endif
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.state !== 4'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL idle_no_start state=%0d busy=%b exp=0/0", bus.state, bus.busy); end
    $display("test_reset done");
  endtask

  task automatic one_case(input string name, input logic [4:0] x, input logic [4:0] y, input logic [4:0] r);
    logic [10:0] o;
    logic okv;
    int dc, dcnt, bcnt, exp_o;
    run_op(x, y, r, o, okv, dc, dcnt, bcnt);
    exp_o = model_o(int'(x), int'(y));
    checks++; if (int'(o) !== exp_o) begin failures++; $display("FAIL %s_O x=%0d y=%0d got=%0d exp=%0d", name, x, y, o, exp_o); end
    checks++; if (dc !== LAT) begin failures++; $display("FAIL %s_done_cycle got=%0d exp=%0d", name, dc, LAT); end
    checks++; if (dcnt !== 1) begin failures++; $display("FAIL %s_done_pulses got=%0d exp=1", name, dcnt); end
    checks++; if (bcnt !== LAT) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, bcnt, LAT); end
    checks++; if (int'(bus.O) !== exp_o) begin failures++; $display("FAIL %s_O_hold got=%0d exp=%0d", name, bus.O, exp_o); end
`ifdef SQSUM_CHECK_EN
    checks++; if (okv !== model_ok(exp_o, int'(r))) begin failures++; $display("FAIL %s_ok r=%0d got=%b exp=%b", name, r, okv, model_ok(exp_o, int'(r))); end
`endif
    $display("%s x=%0d y=%0d r=%0d O=%0d done_cycle=%0d ok=%b", name, x, y, r, o, dc, okv);
  endtask

  task automatic test_basic();
    one_case("basic", 5'd26, 5'd8, 5'd27);
  endtask

  task automatic test_extremes();
    one_case("max", 5'd31, 5'd31, 5'd31);
    one_case("zero", 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      one_case("rand", 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)));
  endtask

`ifdef SQSUM_CHECK_EN
  task automatic test_check();
    one_case("chk27", 5'd26, 5'd8, 5'd27);
    one_case("chk26", 5'd26, 5'd8, 5'd26);
    one_case("chk31", 5'd26, 5'd8, 5'd31);
  endtask
`endif

  task automatic test_back_to_back();
    int exp_dc[$];
    int got_dc[$];
    logic [10:0] got_o[$];
    for (int k = 0; k * P <= 39; k++) exp_dc.push_back(k * P + LAT);
    bus.in1 = 5'd3; bus.in2 = 5'd4;
`ifdef SQSUM_CHECK_EN
    bus.root = 5'd5;
`endif
    bus.start = 1'b1;
    for (int c = 1; c <= 40 + P + 2; c++) begin
      @(posedge clk); #1;
      if (c == 40) bus.start = 1'b0;
      if (c < 40 && (c % P) == 3) begin
        bus.in1 = 5'($urandom_range(31));
        bus.in2 = 5'($urandom_range(31));
      end
      if (c < 40 && (c % P) == LAT) begin
        bus.in1 = 5'd3; bus.in2 = 5'd4;
      end
      if (bus.done) begin
        got_dc.push_back(c);
        got_o.push_back(bus.O);
      end
    end
    checks++; if (got_dc.size() !== exp_dc.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_dc.size(), exp_dc.size()); end
    for (int i = 0; i < got_dc.size() && i < exp_dc.size(); i++) begin
      checks++; if (got_dc[i] !== exp_dc[i]) begin failures++; $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", i, got_dc[i], exp_dc[i]); end
      checks++; if (int'(got_o[i]) !== model_o(3, 4)) begin failures++; $display("FAIL b2b_O[%0d] got=%0d exp=%0d", i, got_o[i], model_o(3, 4)); end
      $display("b2b op=%0d done_cycle=%0d O=%0d", i, got_dc[i], got_o[i]);
    end
  endtask

  task automatic test_reset_midrun();
    bit found;
    int stray_done;
    bus.in1 = 5'($urandom_range(31)); bus.in2 = 5'($urandom_range(31));
    bus.start = 1'b1;
    found = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.state === 4'd3) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL midrun_reach_sq2 got=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.state !== 4'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL midrun_async state=%0d busy=%b exp=0/0", bus.state, bus.busy); end
    checks++; if (bus.O !== 11'd0) begin failures++; $display("FAIL midrun_O got=%0d exp=0", bus.O); end
    stray_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done) stray_done++;
    end
    checks++; if (stray_done !== 0) begin failures++; $display("FAIL midrun_no_done got=%0d exp=0", stray_done); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset_midrun state_after=%0d", bus.state);
    one_case("after_reset", 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)));
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    checks = 0;
    failures = 0;
    bus.start = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
`ifdef SQSUM_CHECK_EN
    bus.root = '0;
`endif
    test_reset();
    test_basic();
    test_extremes();
    test_random();
`ifdef SQSUM_CHECK_EN
    test_check();
`endif
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
